// File: rtl/demux_sched.sv
// demux_sched: scheduler in front of a 1-to-4 demultiplexer.
// A single holding register takes words from a valid/ready input stream.
// Each held word goes to one channel, chosen round-robin or by in_dest.
// A held word that waits on a stalled channel for too long is dropped.
//
// Optional feature macro: DEMUX_SCHED_SKIP_EN
//   defined   : in round-robin mode, channels whose out_ready is low are skipped
//   undefined : strict round-robin, sel = rr_ptr whatever out_ready says
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | holding register empty, in_ready=1
// HOLD  | word latched, out_valid[sel]=1, wait_cnt counts stalled cycles
module demux_sched #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mode,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [1:0]    in_dest,
    output logic [1:0]    sel,
    output logic [DW-1:0] out_data,
    output logic [3:0]    out_valid,
    input  logic [3:0]    out_ready,
    output logic          drop
);

    // The timeout counter is 8 bits wide, so TIMEOUT is limited to 255.
    // TIMEOUT == 0 turns dropping off, and the counter then saturates.
    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);
    localparam bit         TO_EN  = (TIMEOUT != 0);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state_q,    state_d;
    logic [1:0]      sel_q,      sel_d;
    logic [DW-1:0]   data_q,     data_d;
    logic [1:0]      rr_ptr_q,   rr_ptr_d;
    logic [7:0]      wait_cnt_q, wait_cnt_d;
    logic            mode_q,     mode_d;
    logic            drop_q,     drop_d;

    logic            xfer;
    logic            timeout_hit;
    logic            accept;
    logic [1:0]      rr_base;
    logic [1:0]      rr_choice;
    logic [1:0]      new_sel;

    // Handshake and timeout qualification for the word currently held.
    always_comb begin
        xfer        = (state_q == HOLD) && out_ready[sel_q];
        timeout_hit = (state_q == HOLD) && !xfer && TO_EN && (wait_cnt_q == TO_CNT);
        in_ready    = (state_q == IDLE) || xfer;
        accept      = in_valid && in_ready;
    end

    // The round-robin pointer moves past the channel of a word that leaves,
    // through either a transfer or a drop. It moves only if that word was accepted
    // in round-robin mode. A word accepted in the same cycle sees the moved pointer.
    always_comb begin
        rr_base = rr_ptr_q;
        if ((xfer || timeout_hit) && !mode_q) begin
            rr_base = sel_q + 2'd1;
        end
    end

`ifdef DEMUX_SCHED_SKIP_EN
    // Pick the first ready channel at or after the pointer. If none is ready, use the pointer.
    always_comb begin
        logic       found;
        logic [1:0] cand;
        rr_choice = rr_base;
        found     = 1'b0;
        cand      = rr_base;
        for (int k = 0; k < 4; k++) begin
            cand = rr_base + 2'(k);
            if (!found && out_ready[cand]) begin
                rr_choice = cand;
                found     = 1'b1;
            end
        end
    end
`else
    // Strict rotation: the pointer alone selects the channel.
    always_comb begin
        rr_choice = rr_base;
    end
`endif

    // Channel for a word accepted this cycle; mode is sampled only here.
    always_comb begin
        new_sel = mode ? in_dest : rr_choice;
    end

    // Next-state logic for the holding register, the pointer and the timeout counter.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        data_d     = data_q;
        mode_d     = mode_q;
        wait_cnt_d = wait_cnt_q;
        rr_ptr_d   = rr_base;
        drop_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = HOLD;
                    sel_d      = new_sel;
                    data_d     = in_data;
                    mode_d     = mode;
                    wait_cnt_d = 8'd0;
                end
            end
            HOLD: begin
                if (accept) begin
                    // Back-to-back: the held word leaves and the new one replaces it.
                    sel_d      = new_sel;
                    data_d     = in_data;
                    mode_d     = mode;
                    wait_cnt_d = 8'd0;
                end else if (xfer) begin
                    state_d    = IDLE;
                    wait_cnt_d = 8'd0;
                end else if (timeout_hit) begin
                    state_d    = IDLE;
                    wait_cnt_d = 8'd0;
                    drop_d     = 1'b1;
                end else if (wait_cnt_q != 8'hFF) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= 2'd0;
            data_q     <= '0;
            rr_ptr_q   <= 2'd0;
            wait_cnt_q <= 8'd0;
            mode_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            data_q     <= data_d;
            rr_ptr_q   <= rr_ptr_d;
            wait_cnt_q <= wait_cnt_d;
            mode_q     <= mode_d;
            drop_q     <= drop_d;
        end
    end

    // Outputs are decoded from registers only, so out_valid is always one-hot or zero.
    always_comb begin
        sel       = sel_q;
        out_data  = data_q;
        drop      = drop_q;
        out_valid = (state_q == HOLD) ? (4'b0001 << sel_q) : 4'b0000;
    end

endmodule

// File: tb/tb_demux_sched.sv
// Bench for demux_sched with TIMEOUT=4. A transaction-level model tracks the
// held word and how many cycles it has been visible. The outputs are compared
// with the model on every falling edge. Directed steps also check hand-computed literals.
module tb_demux_sched;

    localparam int DW      = 8;
    localparam int TIMEOUT = 4;

    logic          clk;
    logic          rst_n;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [1:0]    in_dest;
    logic [1:0]    sel;
    logic [DW-1:0] out_data;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic          drop;

    int n_pass  = 0;
    int n_total = 0;

    demux_sched #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop      (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model of the holding register: a word plus its visible age.
    typedef struct {
        bit         valid;
        logic [7:0] data;
        logic [1:0] sel;
        bit         mode;
        int         age;
        logic [1:0] rr;
        bit         drop;
    } model_t;

    model_t m = '{valid: 0, data: 8'h00, sel: 2'd0, mode: 0, age: 0, rr: 2'd0, drop: 0};

    function automatic model_t step(model_t c, bit md, bit iv, logic [7:0] id,
                                    logic [1:0] dst, logic [3:0] ordy);
        model_t n;
        bit     hs;
        bit     ready;
        bit     found;
        n      = c;
        n.drop = 0;
        hs     = c.valid && ordy[c.sel];
        ready  = !c.valid || hs;
        if (c.valid) begin
            if (hs || (TIMEOUT != 0 && c.age == TIMEOUT + 1)) begin
                n.valid = 0;
                n.drop  = !hs;
                if (!c.mode) n.rr = 2'((int'(c.sel) + 1) % 4);
            end else begin
                n.age = c.age + 1;
            end
        end
        if (iv && ready) begin
            n.valid = 1;
            n.data  = id;
            n.mode  = md;
            n.age   = 1;
            if (md) begin
                n.sel = dst;
            end else begin
                n.sel = n.rr;
`ifdef DEMUX_SCHED_SKIP_EN
                found = 0;
                for (int k = 0; k < 4; k++) begin
                    if (!found && ordy[(int'(n.rr) + k) % 4]) begin
                        n.sel = 2'((int'(n.rr) + k) % 4);
                        found = 1;
                    end
                end
`else
                found = 0;
`endif
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{valid: 0, data: 8'h00, sel: 2'd0, mode: 0, age: 0, rr: 2'd0, drop: 0};
        else        m <= step(m, mode, in_valid, in_data, in_dest, out_ready);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cmp_out_valid", 32'(out_valid), m.valid ? 32'(4'b0001 << m.sel) : 32'd0);
            chk("cmp_drop", 32'(drop), 32'(m.drop));
            chk("cmp_in_ready", 32'(in_ready), 32'(!m.valid || out_ready[m.sel]));
            if (m.valid) begin
                chk("cmp_sel", 32'(sel), 32'(m.sel));
                chk("cmp_out_data", 32'(out_data), 32'(m.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    logic [1:0] dst_tab [3];
    logic [3:0] ov_tab  [3];

    initial begin
        dst_tab   = '{2'd3, 2'd3, 2'd1};
        ov_tab    = '{4'b1000, 4'b1000, 4'b0010};
        rst_n     = 1'b0;
        mode      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_dest   = 2'd0;
        out_ready = 4'b0000;
        repeat (2) tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back round-robin
        out_ready = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            in_data  = 8'(8'h10 + i);
            in_valid = 1'b1;
            tick();
            chk("rr_sel", 32'(sel), 32'(i % 4));
            chk("rr_data", 32'(out_data), 32'(8'h10 + i));
            chk("rr_in_ready", 32'(in_ready), 32'd1);
            chk("rr_drop", 32'(drop), 32'd0);
        end
        in_valid = 1'b0;
        tick();
        chk("rr_drain", 32'(out_valid), 32'd0);

        // Directed mode
        mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data  = 8'(8'hA0 + i);
            in_dest  = dst_tab[i];
            in_valid = 1'b1;
            tick();
            chk("dir_out_valid", 32'(out_valid), 32'(ov_tab[i]));
        end
        in_valid = 1'b0;
        tick();

        // Pointer untouched by directed words, then skip behaviour
        mode     = 1'b0;
        in_data  = 8'h30;
        in_valid = 1'b1;
        tick();
        chk("dir_rr_kept", 32'(sel), 32'd0);
        in_data   = 8'h55;
        out_ready = 4'b1001;
        tick();
`ifdef DEMUX_SCHED_SKIP_EN
        chk("skip_sel", 32'(sel), 32'd3);
        in_data = 8'h56;
        tick();
        chk("skip_next_sel", 32'(sel), 32'd0);
        in_valid = 1'b0;
        tick();
`else
        chk("strict_sel", 32'(sel), 32'd1);
        in_valid = 1'b0;
        repeat (2) begin
            tick();
            chk("strict_stall_valid", 32'(out_valid), 32'b0010);
            chk("strict_stall_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 4'b1111;
        tick();
        chk("strict_release", 32'(out_valid), 32'd0);
`endif

        // Timeout drop
        out_ready = 4'b0000;
        mode      = 1'b1;
        in_dest   = 2'd2;
        in_data   = 8'h77;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("to_valid", 32'(out_valid), 32'b0100);
        repeat (4) begin
            tick();
            chk("to_valid", 32'(out_valid), 32'b0100);
            chk("to_no_drop", 32'(drop), 32'd0);
        end
        tick();
        chk("to_drop", 32'(drop), 32'd1);
        chk("to_idle", 32'(out_valid), 32'd0);
        chk("to_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("to_drop_pulse", 32'(drop), 32'd0);

        // Transfer in the same cycle the timeout is reached
        in_dest  = 2'd1;
        in_data  = 8'h88;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("col_stall_ready", 32'(in_ready), 32'd0);
        repeat (4) begin
            tick();
            chk("col_stall_ready", 32'(in_ready), 32'd0);
            chk("col_stall_valid", 32'(out_valid), 32'b0010);
        end
        out_ready = 4'b0010;
        tick();
        chk("col_done", 32'(out_valid), 32'd0);
        chk("col_no_drop", 32'(drop), 32'd0);
        tick();
        chk("col_no_drop2", 32'(drop), 32'd0);

        // Reset while holding
        out_ready = 4'b0000;
        in_data   = 8'h99;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mr_valid", 32'(out_valid), 32'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_sel", 32'(sel), 32'd0);
        chk("mr_drop", 32'(drop), 32'd0);
        tick();
        rst_n     = 1'b1;
        mode      = 1'b0;
        out_ready = 4'b1111;
        in_data   = 8'h42;
        in_valid  = 1'b1;
        tick();
        chk("mr_next_sel", 32'(sel), 32'd0);
        in_valid = 1'b0;
        tick();

        // Mixed traffic checked against the model
        for (int i = 0; i < 300; i++) begin
            mode      = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_dest   = 2'($urandom_range(0, 3));
            out_ready = 4'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 4'b1111;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
